// File: rtl/uart_prefetch_unit_pkg.sv
// Shared types and sizing helpers for the UART instruction prefetcher.
package uart_prefetch_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    RECV,
    PUSH
  } pf_state_e;

  localparam logic [7:0] CMD_FETCH_DEF = 8'h03;

  function automatic int unsigned nbytes(input int unsigned w);
    return w / 8;
  endfunction

  // Bits needed to index n distinct values (minimum 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_prefetch_unit_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush and register-array head.
module prefetch_fifo
  import uart_prefetch_unit_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [W-1:0]              push_data_i,
  input  logic                      pop_i,
  output logic [W-1:0]              head_o,
  output logic [cnt_w(DEPTH+1)-1:0] count_o
);

  localparam int PW = cnt_w(DEPTH);
  localparam int CW = cnt_w(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_prefetch_unit.sv
// UART instruction prefetcher: serialises fetch requests, queues responses.
module uart_prefetch_unit
  import uart_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                INSTR_W     = 16,
  parameter int                DEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter logic [7:0]        CMD_FETCH   = CMD_FETCH_DEF,
  parameter int                TIMEOUT_CYC = 0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_done,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  input  logic               stall_uart,
  output logic               own_uart,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_addr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               timeout_err
);

  localparam int AB  = nbytes(ADDR_W);
  localparam int IB  = nbytes(INSTR_W);
  localparam int TXW = cnt_w(AB + 1);
  localparam int RXW = cnt_w(IB);
  localparam int TOW = cnt_w(TIMEOUT_CYC + 1);
  localparam int CW  = cnt_w(DEPTH + 1);
  localparam int EW  = ADDR_W + INSTR_W;

  pf_state_e          state_q;
  logic [ADDR_W-1:0]  fetch_addr_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [INSTR_W-1:0] instr_sh_q;
  logic [TXW-1:0]     tx_idx_q;
  logic [RXW-1:0]     rx_cnt_q;
  logic [TOW-1:0]     tmo_q;
  logic               discard_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               own_q;
  logic               tmo_err_q;

  logic [CW-1:0]      count;
  logic [EW-1:0]      head;
  logic               push;
  logic               pop;
  logic               can_start;
  logic               last_tx;
  logic               last_rx;
  logic               tmo_hit;
  logic [TXW-1:0]     tx_idx_nx;
  logic [7:0]         nx_byte;

  // Byte idx of a request: 0 is the command, then address MSB first.
  function automatic logic [7:0] req_byte(
    input logic [ADDR_W-1:0] a,
    input logic [TXW-1:0]    idx
  );
    logic [7:0] b;
    b = CMD_FETCH;
    for (int k = 1; k <= AB; k++)
      if (int'(idx) == k) b = a[(AB-k)*8 +: 8];
    return b;
  endfunction

  assign tx_idx_nx = tx_idx_q + 1'b1;
  assign nx_byte   = req_byte(req_addr_q, tx_idx_nx);
  assign last_tx   = (tx_idx_q == TXW'(AB));
  assign last_rx   = (rx_cnt_q == RXW'(IB - 1));
  assign can_start = (count < CW'(DEPTH)) && !stall_uart
                   && !redirect_valid;
  assign tmo_hit   = (TIMEOUT_CYC > 0) && (state_q == RECV) && !rx_done
                   && (tmo_q == TOW'(TIMEOUT_CYC - 1));
  assign push      = (state_q == PUSH) && !discard_q && !redirect_valid;
  assign pop       = instr_valid && instr_ready && !redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_ADDR;
      req_addr_q   <= RESET_ADDR;
      instr_sh_q   <= '0;
      tx_idx_q     <= '0;
      rx_cnt_q     <= '0;
      tmo_q        <= '0;
      discard_q    <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      own_q        <= 1'b0;
      tmo_err_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      tmo_err_q  <= 1'b0;
      if (redirect_valid) begin
        fetch_addr_q <= redirect_addr;
        if (state_q inside {SEND, WAIT_TX, RECV}) discard_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (can_start) begin
            state_q    <= SEND;
            own_q      <= 1'b1;
            req_addr_q <= fetch_addr_q;
            tx_idx_q   <= '0;
            tx_start_q <= 1'b1;
            tx_data_q  <= CMD_FETCH;
          end
        end
        SEND: state_q <= WAIT_TX;
        WAIT_TX: begin
          if (tx_done) begin
            if (last_tx) begin
              state_q  <= RECV;
              rx_cnt_q <= '0;
              tmo_q    <= '0;
            end else begin
              state_q    <= SEND;
              tx_idx_q   <= tx_idx_nx;
              tx_start_q <= 1'b1;
              tx_data_q  <= nx_byte;
            end
          end
        end
        RECV: begin
          if (rx_done) begin
            instr_sh_q <= (instr_sh_q << 8) | INSTR_W'(rx_data);
            rx_cnt_q   <= rx_cnt_q + 1'b1;
            tmo_q      <= '0;
            if (last_rx) state_q <= PUSH;
          end else if (tmo_hit) begin
            // Host went silent: replay the same request from the top.
            tmo_err_q  <= 1'b1;
            state_q    <= SEND;
            tx_idx_q   <= '0;
            rx_cnt_q   <= '0;
            tx_start_q <= 1'b1;
            tx_data_q  <= CMD_FETCH;
          end else if (TIMEOUT_CYC > 0) begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        PUSH: begin
          state_q   <= IDLE;
          own_q     <= 1'b0;
          discard_q <= 1'b0;
          if (!discard_q && !redirect_valid)
            fetch_addr_q <= fetch_addr_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  prefetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ({req_addr_q, instr_sh_q}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign own_uart    = own_q;
  assign timeout_err = tmo_err_q;
  assign instr_valid = (count != '0);
  assign instr_addr  = head[EW-1:INSTR_W];
  assign instr_data  = head[INSTR_W-1:0];

endmodule

// File: tb/tb_uart_prefetch_unit.sv
// Bench for uart_prefetch_unit: host models, table vectors, random stream.
module tb_uart_prefetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(negedge clk) cyc++;

  logic        a_rst_n, a_tx_start, a_tx_done, a_rx_done, a_stall;
  logic        a_own, a_valid, a_ready, a_redir, a_terr;
  logic [7:0]  a_tx_data, a_rx_data, a_iaddr, a_raddr;
  logic [15:0] a_idata;

  logic        b_rst_n, b_tx_start, b_tx_done, b_rx_done, b_stall;
  logic        b_own, b_valid, b_ready, b_redir, b_terr;
  logic [7:0]  b_tx_data, b_rx_data;
  logic [15:0] b_iaddr, b_raddr;
  logic [31:0] b_idata;

  uart_prefetch_unit #(
    .ADDR_W(8), .INSTR_W(16), .DEPTH(4), .RESET_ADDR(8'h00),
    .CMD_FETCH(8'h03), .TIMEOUT_CYC(100)
  ) dut_a (
    .clk(clk), .reset(a_rst_n), .tx_start(a_tx_start),
    .tx_data(a_tx_data), .tx_done(a_tx_done), .rx_done(a_rx_done),
    .rx_data(a_rx_data), .stall_uart(a_stall), .own_uart(a_own),
    .instr_valid(a_valid), .instr_ready(a_ready), .instr_data(a_idata),
    .instr_addr(a_iaddr), .redirect_valid(a_redir),
    .redirect_addr(a_raddr), .timeout_err(a_terr)
  );

  uart_prefetch_unit #(
    .ADDR_W(16), .INSTR_W(32), .DEPTH(4), .RESET_ADDR(16'h1234),
    .CMD_FETCH(8'h03), .TIMEOUT_CYC(0)
  ) dut_b (
    .clk(clk), .reset(b_rst_n), .tx_start(b_tx_start),
    .tx_data(b_tx_data), .tx_done(b_tx_done), .rx_done(b_rx_done),
    .rx_data(b_rx_data), .stall_uart(b_stall), .own_uart(b_own),
    .instr_valid(b_valid), .instr_ready(b_ready), .instr_data(b_idata),
    .instr_addr(b_iaddr), .redirect_valid(b_redir),
    .redirect_addr(b_raddr), .timeout_err(b_terr)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Host A: answers a request for addr N with 16'hA000+N.
  logic [7:0] a_log[$];
  int a_drop = 0;
  int a_rsp_addr = -1;
  int a_rsp_sent = 0;
  int a_t_first = 0;
  initial begin : host_a
    logic [7:0]  req[$];
    logic [7:0]  rsp[$];
    logic [15:0] v;
    int dly, gap;
    dly = 0; gap = 0;
    a_tx_done = 0; a_rx_done = 0; a_rx_data = 0;
    forever begin
      @(negedge clk);
      a_tx_done = 0; a_rx_done = 0;
      if (!a_rst_n) begin
        req.delete(); rsp.delete(); dly = 0;
      end else if (a_tx_start) begin
        a_log.push_back(a_tx_data); req.push_back(a_tx_data); dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          a_tx_done = 1;
          if (req.size() == 2) begin
            v = 16'hA000 + {8'h00, req[1]};
            rsp.push_back(v[15:8]);
            if (a_drop > 0) a_drop--;
            else rsp.push_back(v[7:0]);
            a_rsp_addr = int'(req[1]); a_rsp_sent = 0; gap = 3;
            req.delete();
          end
        end
      end else if (rsp.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          a_rx_done = 1; a_rx_data = rsp.pop_front();
          a_rsp_sent++;
          if (a_rsp_sent == 1) a_t_first = cyc;
          gap = 3;
        end
      end
    end
  end

  // Host B: answers addr N with 32'hDEADBEEF + (N - 16'h1234).
  logic [7:0] b_log[$];
  initial begin : host_b
    logic [7:0]  req[$];
    logic [7:0]  rsp[$];
    logic [31:0] v;
    int dly, gap;
    dly = 0; gap = 0;
    b_tx_done = 0; b_rx_done = 0; b_rx_data = 0;
    forever begin
      @(negedge clk);
      b_tx_done = 0; b_rx_done = 0;
      if (!b_rst_n) begin
        req.delete(); rsp.delete(); dly = 0;
      end else if (b_tx_start) begin
        b_log.push_back(b_tx_data); req.push_back(b_tx_data); dly = 2;
      end else if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          b_tx_done = 1;
          if (req.size() == 3) begin
            v = 32'hDEADBEEF + {16'h0, req[1], req[2]} - 32'h1234;
            for (int k = 3; k >= 0; k--) rsp.push_back(v[k*8 +: 8]);
            gap = 3;
            req.delete();
          end
        end
      end else if (rsp.size() > 0) begin
        if (gap > 0) gap--;
        else begin
          b_rx_done = 1; b_rx_data = rsp.pop_front(); gap = 3;
        end
      end
    end
  end

  // Stream model: consumer must see consecutive addresses from the
  // last redirect (or reset), each carrying 16'hA000+addr.
  logic [7:0]  m_addr;
  int          pops;
  logic [7:0]  pq_a[$];
  logic [15:0] pq_d[$];
  logic        prev_own, prev_stall;

  task automatic a_cycle(input logic rdy, input logic rd,
                         input logic [7:0] ra, input logic st);
    @(negedge clk);
    if (a_redir) chk("flush_after_redirect", a_valid, 1'b0);
    if (a_own && !prev_own) chk("start_while_stalled", prev_stall, 1'b0);
    prev_own = a_own;
    prev_stall = st;
    if (!rd && rdy && a_valid) begin
      chk("pop_addr", a_iaddr, m_addr);
      chk("pop_data", a_idata, 16'hA000 + {8'h00, m_addr});
      pq_a.push_back(a_iaddr); pq_d.push_back(a_idata);
      m_addr++; pops++;
    end
    a_ready = rdy; a_redir = rd; a_raddr = ra; a_stall = st;
    if (rd) m_addr = ra;
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_rst_n = 0; a_ready = 0; a_redir = 0; a_stall = 0; a_drop = 0;
    repeat (2) @(negedge clk);
    a_log.delete(); a_rsp_addr = -1; a_rsp_sent = 0;
    prev_own = 0; prev_stall = 0; m_addr = 8'h00; pops = 0;
    pq_a.delete(); pq_d.delete();
    a_rst_n = 1;
  endtask

  typedef struct packed {
    logic [7:0]        raddr;
    logic [3:0][7:0]   eaddr;
    logic [3:0][15:0]  edata;
  } rvec_t;

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: run did not complete, %0d failed so far", fails);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    rvec_t      vec[3];
    logic [7:0] fill_exp[8];
    logic [7:0] tmo_exp[4];
    int n, p0, d, nerr;
    logic seen, sawtx;

    vec[0] = '{8'hFE, {8'h01, 8'h00, 8'hFF, 8'hFE},
               {16'hA001, 16'hA000, 16'hA0FF, 16'hA0FE}};
    vec[1] = '{8'h40, {8'h43, 8'h42, 8'h41, 8'h40},
               {16'hA043, 16'hA042, 16'hA041, 16'hA040}};
    vec[2] = '{8'hFF, {8'h02, 8'h01, 8'h00, 8'hFF},
               {16'hA002, 16'hA001, 16'hA000, 16'hA0FF}};
    fill_exp = '{8'h03, 8'h00, 8'h03, 8'h01, 8'h03, 8'h02, 8'h03, 8'h03};
    tmo_exp  = '{8'h03, 8'h00, 8'h03, 8'h00};

    a_rst_n = 0; a_ready = 0; a_redir = 0; a_raddr = 0; a_stall = 0;
    b_rst_n = 0; b_ready = 0; b_redir = 0; b_raddr = 0; b_stall = 0;
    prev_own = 0; prev_stall = 0; m_addr = 0; pops = 0;
    repeat (3) @(negedge clk);

    chk("rst_valid", a_valid, 0);
    chk("rst_tx_start", a_tx_start, 0);
    chk("rst_tx_data", a_tx_data, 0);
    chk("rst_own", a_own, 0);
    chk("rst_terr", a_terr, 0);
    chk("rst_addr", a_iaddr, 0);
    chk("rst_data", a_idata, 0);

    // Fill: no consumer, queue must hold 0..3 and stop requesting.
    do_reset();
    for (int i = 0; i < 2000 && !(a_log.size() >= 8 && !a_own); i++)
      @(negedge clk);
    repeat (50) @(negedge clk);
    chk("fill_log_len", a_log.size(), 8);
    for (int i = 0; i < 8; i++) chk("fill_tx_byte", a_log[i], fill_exp[i]);
    chk("fill_own", a_own, 0);
    chk("fill_valid", a_valid, 1);
    chk("fill_head_addr", a_iaddr, 8'h00);
    chk("fill_head_data", a_idata, 16'hA000);

    // Steady stream A000..A007.
    do_reset();
    for (int i = 0; i < 3000 && pops < 8; i++) a_cycle(1, 0, 0, 0);
    chk("stream_pops", pops, 8);

    // Redirect to 40 while addr 5 is mid-response.
    do_reset();
    for (int i = 0; i < 3000 && !(a_rsp_addr == 5 && a_rsp_sent == 1); i++)
      a_cycle(1, 0, 0, 0);
    chk("rd_reached_5", a_rsp_addr, 5);
    n = a_log.size();
    a_cycle(1, 1, 8'h40, 0);
    p0 = pops;
    for (int i = 0; i < 1000 && pops == p0; i++) a_cycle(1, 0, 0, 0);
    chk("rd_tx_cmd", a_log[n], 8'h03);
    chk("rd_tx_addr", a_log[n+1], 8'h40);
    chk("rd_first_pop", pq_a[p0], 8'h40);

    // Table-driven redirects, including the FF->00 wrap.
    for (int v = 0; v < 3; v++) begin
      a_cycle(0, 1, vec[v].raddr, 0);
      pq_a.delete(); pq_d.delete();
      for (int i = 0; i < 1000 && pq_a.size() < 4; i++) a_cycle(1, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
        chk("vec_addr", pq_a[k], vec[v].eaddr[k]);
        chk("vec_data", pq_d[k], vec[v].edata[k]);
      end
    end

    // Stall raised mid-request: finishes, then link stays idle.
    do_reset();
    for (int i = 0; i < 200 && a_log.size() < 1; i++) @(negedge clk);
    a_stall = 1;
    for (int i = 0; i < 200 && a_own; i++) @(negedge clk);
    chk("stall_own_low", a_own, 0);
    chk("stall_log_len", a_log.size(), 2);
    chk("stall_pushed", a_valid, 1);
    chk("stall_head", a_iaddr, 8'h00);
    sawtx = 0;
    repeat (30) begin
      @(negedge clk);
      if (a_tx_start || a_own) sawtx = 1;
    end
    chk("stall_no_tx", sawtx, 0);
    a_stall = 0;
    @(negedge clk);
    chk("resume_tx_start", a_tx_start, 1);
    chk("resume_own", a_own, 1);

    // Timeout: second response byte of addr 0 is lost.
    do_reset();
    a_drop = 1;
    seen = 0; nerr = 0; d = 0;
    for (int i = 0; i < 800 && !(seen && !a_own && a_log.size() >= 10); i++)
    begin
      @(negedge clk);
      if (a_terr) begin
        nerr++;
        if (!seen) d = cyc - a_t_first;
        seen = 1;
      end
    end
    chk("tmo_seen", seen, 1);
    chk("tmo_pulses", nerr, 1);
    chk("tmo_delay", (d >= 99 && d <= 103) ? 101 : d, 101);
    for (int i = 0; i < 4; i++) chk("tmo_tx_byte", a_log[i], tmo_exp[i]);
    for (int i = 0; i < 400 && pops < 4; i++) a_cycle(1, 0, 0, 0);
    chk("tmo_pops", pops, 4);

    // Random consumer, stalls and redirects against the stream model.
    do_reset();
    for (int i = 0; i < 4000; i++)
      a_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
              8'($urandom), ($urandom_range(0, 7) == 0));
    a_cycle(0, 0, 0, 0);
    chk("rand_progress", pops > 100, 1);

    // Wide configuration: 16-bit address, 32-bit instruction.
    @(negedge clk);
    b_rst_n = 1;
    for (int i = 0; i < 500 && !b_valid; i++) @(negedge clk);
    chk("b_valid", b_valid, 1);
    chk("b_tx0", b_log[0], 8'h03);
    chk("b_tx1", b_log[1], 8'h12);
    chk("b_tx2", b_log[2], 8'h34);
    chk("b_addr", b_iaddr, 16'h1234);
    chk("b_data", b_idata, 32'hDEADBEEF);
    b_ready = 1;
    @(negedge clk);
    b_ready = 0;
    for (int i = 0; i < 500 && !(b_valid && b_log.size() >= 6); i++)
      @(negedge clk);
    chk("b_tx5", b_log[5], 8'h35);
    chk("b_addr2", b_iaddr, 16'h1235);
    chk("b_data2", b_idata, 32'hDEADBEF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_prefetch_unit.md
Name: uart_prefetch_unit

Overview:
Parametrised successor to the single-shot UART instruction fetcher. It requests instructions from the host over the shared UART byte interface, ahead of execution, and buffers them in a DEPTH-entry prefetch queue. Instructions go to the core/sequencer through a valid/ready handshake. A redirect (branch) flushes the queue; the UART link is yielded to the core for load/store traffic on request.

Parameters:
ADDR_W, 8, fetch address width in bits; must be a multiple of 8 (ADDR_BYTES = ADDR_W/8).
INSTR_W, 16, instruction width in bits; must be a multiple of 8 (INSTR_BYTES = INSTR_W/8).
DEPTH, 4, prefetch queue entries; power of two, >=2.
RESET_ADDR, 0, fetch address after reset.
CMD_FETCH, 8'h03, command byte that opens every fetch request.
TIMEOUT_CYC, 0, max clk cycles between response bytes; 0 disables the timeout.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
tx_start  out  1  one-cycle pulse: UART transmits tx_data
tx_data  out  8  byte to transmit
tx_done  in  1  one-cycle pulse: UART finished the byte
rx_done  in  1  one-cycle pulse: rx_data holds a new byte
rx_data  in  8  received byte
stall_uart  in  1  core needs the UART; do not start a new request
own_uart  out  1  high while a request/response is in flight; top-level tx mux selects this block
instr_valid  out  1  queue head valid
instr_ready  in  1  consumer pops head when valid&ready
instr_data  out  INSTR_W  head instruction
instr_addr  out  ADDR_W  address of head instruction
redirect_valid  in  1  flush and restart fetching at redirect_addr
redirect_addr  in  ADDR_W  new fetch address
timeout_err  out  1  one-cycle pulse on response timeout

Behaviour:
- Reset values: all outputs 0; fetch_addr = RESET_ADDR; queue empty; FSM in IDLE; discard flag 0.
- One request on the wire: CMD_FETCH, then ADDR_BYTES bytes of fetch_addr MSB first, then INSTR_BYTES response bytes MSB first.
- At most one request in flight. Start condition in IDLE: queue count < DEPTH and !stall_uart. A push is therefore always guaranteed a free slot.
- FSM states:
  - IDLE -> SEND when the start condition holds; own_uart rises that cycle.
  - SEND: tx_start=1 for exactly one cycle, tx_data = current byte -> WAIT_TX.
  - WAIT_TX: hold tx_data until tx_done. Then -> SEND for the next byte, or -> RECV after the last address byte.
  - RECV: shift rx_data in on each rx_done. After INSTR_BYTES bytes -> PUSH.
  - PUSH: write {addr, instr} unless discard=1; fetch_addr <= fetch_addr+1 unless discard=1; clear discard; own_uart falls -> IDLE.
- rx_done outside RECV is ignored, since the core owns those bytes.
- Address arithmetic: fetch_addr+1 wraps modulo 2^ADDR_W (all-ones -> 0).
- Latency: entry written in PUSH appears at instr_valid the next cycle. Pop and push in the same cycle are both honoured; count is unchanged.
- instr_valid = queue not empty; instr_data/instr_addr come from the head register (no combinational path from rx_data).
- Redirect handling: redirect_valid has priority over pop and push in the same cycle.
  - Queue is cleared and fetch_addr <= redirect_addr.
  - If a request is in flight, it completes on the wire (UART bytes cannot be aborted), discard is set, and its response is dropped.
  - Redirect during PUSH drops that push.
- stall_uart: only gates starting a request; an in-flight request always completes. The sequencer waits for own_uart=0 before using the UART.
- Timeout (TIMEOUT_CYC>0):
  - A counter runs in RECV and resets on each rx_done.
  - On reaching TIMEOUT_CYC: pulse timeout_err, discard partial bytes, and re-send the same request from SEND. fetch_addr is unchanged; own_uart stays high.
- Asynchronous reset mid-transaction: everything returns to reset values immediately. Late UART bytes are ignored because the FSM is in IDLE.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SEND, WAIT_TX, RECV, PUSH).
  - CMD_FETCH default.
  - ADDR_BYTES/INSTR_BYTES byte-count functions.
  - clog2-based counter-width constants.
- One sub-module, prefetch_fifo: synchronous FIFO of {ADDR_W+INSTR_W} x DEPTH with push, pop, flush, count, and registered head outputs.
- Request/response FSM and byte serializer stay in the top.

Test Plan:
- Reset with RESET_ADDR=0, instr_ready=0, host model answering addr N with 16'hA000+N. Required: tx bytes 03,00,03,01,03,02,03,03; queue fills to 4 entries; no fifth request; instr_addr/instr_data = 0/A000.
- Steady stream, instr_ready=1. Required: instructions A000..A007 popped in order; address wraps 8'hFF -> 8'h00 when started at RESET_ADDR=8'hFE.
- redirect_valid with redirect_addr=8'h40 asserted while the response to addr 5 is mid-RECV. Required: 5's response dropped; queue empty next cycle; next tx bytes 03,40; first popped addr 8'h40.
- stall_uart=1 raised during WAIT_TX of a request. Required: request completes and pushes; own_uart falls; no tx_start while stall_uart=1; fetching resumes one cycle after release.
- TIMEOUT_CYC=100, host drops the second response byte. Required: timeout_err pulse 100 cycles after the first byte; same request re-sent; correct instruction pushed once.
- ADDR_W=16, INSTR_W=32. Required: request 03,12,34 for addr 16'h1234; 4 response bytes DE,AD,BE,EF give instr_data 32'hDEADBEEF.
